// File: rtl/kanagawa_fifo_read_prefetch.sv
// kanagawa_fifo_read_prefetch
//
// Read-side stage behind the FIFO pointer tracker. It issues reads to a
// synchronous RAM of fixed latency and walks the read address. Returned
// words land in a small prefetch buffer, which is presented to the
// consumer over valid/ready. Reads are only issued while the in-flight
// plus buffered total is below CAP, so returned data always has a slot.
// rdreq depends only on registers and the registered `empty`, so there is
// no combinational path from out_ready to rdreq.
//
// Ports:
//   clk         clock
//   rst         synchronous, active-high reset
//   empty       from the pointer tracker (registered)
//   rdreq       pop request to the pointer tracker; also the RAM read enable
//   ram_rdaddr  RAM read address, valid while rdreq=1
//   ram_rddata  RAM read data, valid READ_LATENCY cycles after its rdreq
//   out_valid   prefetch buffer head valid
//   out_data    prefetch buffer head word
//   out_ready   consumer accept; a transfer is out_valid && out_ready
module kanagawa_fifo_read_prefetch #(
    parameter int WIDTH        = 32,
    parameter int LOG_DEPTH    = 5,
    parameter int READ_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 empty,
    output logic                 rdreq,
    output logic [LOG_DEPTH-1:0] ram_rdaddr,
    input  logic [WIDTH-1:0]     ram_rddata,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    input  logic                 out_ready
);

    localparam int CAP = READ_LATENCY + 2;
    localparam int PW  = $clog2(CAP) + 1;
    localparam int IW  = $clog2(CAP);
    localparam logic [PW-1:0] CAP_P = PW'(CAP);

    logic                    hold;
    logic [PW-1:0]           occupancy;
    logic [READ_LATENCY-1:0] inflight;
    logic [LOG_DEPTH-1:0]    rd_addr;
    logic [WIDTH-1:0]        mem [CAP];
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic [PW-1:0]           count;
    logic                    pop;
    logic                    wr_en;

    // Pointers wrap at CAP, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        if (p == CAP_P - PW'(1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    // The upstream empty flag comes out of reset low even though the FIFO
    // is empty, so issue is suppressed during rst and for one cycle after.
    assign rdreq      = !rst && !hold && !empty && (occupancy < CAP_P);
    assign ram_rdaddr = rd_addr;
    assign pop        = out_valid && out_ready;
    assign wr_en      = inflight[READ_LATENCY-1];
    assign out_valid  = (count != '0);
    assign out_data   = mem[rd_ptr[IW-1:0]];

    // Control state: hold flag, read address, in-flight shift register,
    // occupancy and buffer pointers. A reset discards in-flight reads by
    // clearing the shift register, so late RAM data is never captured.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold      <= 1'b1;
            rd_addr   <= '0;
            inflight  <= '0;
            occupancy <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            hold <= 1'b0;

            if (rdreq) begin
                rd_addr <= rd_addr + LOG_DEPTH'(1);
            end

            inflight[0] <= rdreq;
            for (int i = 1; i < READ_LATENCY; i++) begin
                inflight[i] <= inflight[i-1];
            end

            if (rdreq && !pop) begin
                occupancy <= occupancy + PW'(1);
            end else if (!rdreq && pop) begin
                occupancy <= occupancy - PW'(1);
            end

            if (wr_en) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end

            if (wr_en && !pop) begin
                count <= count + PW'(1);
            end else if (!wr_en && pop) begin
                count <= count - PW'(1);
            end
        end
    end

    // Buffer storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem[wr_ptr[IW-1:0]] <= ram_rddata;
        end
    end

    // Simulation checks of the internal invariants.
    logic             stall_q;
    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= 1'b0;
        end else begin
            stall_q <= out_valid && !out_ready;
        end
        data_q <= out_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(rdreq && empty));
            assert (occupancy <= CAP_P);
            assert (!(wr_en && count == CAP_P));
            if (stall_q) begin
                assert (out_valid && out_data == data_q);
            end
        end
    end

endmodule

// File: tb/tb_kanagawa_fifo_read_prefetch.sv
// Testbench for kanagawa_fifo_read_prefetch with LOG_DEPTH=4,
// READ_LATENCY=2 (CAP=4), WIDTH=32. A behavioural RAM returns ramMem
// contents two cycles after each rdreq. Inputs change 1 time unit after
// the rising edge; outputs are sampled on the falling edge.
module tb_kanagawa_fifo_read_prefetch;

    localparam int WIDTH     = 32;
    localparam int LOG_DEPTH = 4;
    localparam int RL        = 2;
    localparam int CAP       = RL + 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 empty;
    logic                 rdreq;
    logic [LOG_DEPTH-1:0] ram_rdaddr;
    logic [WIDTH-1:0]     ram_rddata;
    logic                 out_valid;
    logic [WIDTH-1:0]     out_data;
    logic                 out_ready;

    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct {
        logic        rst;
        logic        empty;
        logic        ready;
        logic        expRdreq;
        logic [3:0]  expAddr;
        logic        expValid;
        logic [31:0] expData;
    } vec_t;

    vec_t vecs [15];

    logic [31:0] ramMem [16];
    logic [31:0] ramPipe0;
    logic [31:0] ramPipe1;
    logic [31:0] expQ [$];
    logic [3:0]  expAddr;
    int          transfers;

    always #5 clk = ~clk;

    kanagawa_fifo_read_prefetch #(
        .WIDTH(WIDTH),
        .LOG_DEPTH(LOG_DEPTH),
        .READ_LATENCY(RL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .empty(empty),
        .rdreq(rdreq),
        .ram_rdaddr(ram_rdaddr),
        .ram_rddata(ram_rddata),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_ready(out_ready)
    );

    // Two-stage RAM read pipeline; unrequested slots carry a poison word.
    always @(posedge clk) begin
        ramPipe1 <= ramPipe0;
        ramPipe0 <= rdreq ? ramMem[ram_rdaddr] : 32'hDEADBEEF;
    end
    assign ram_rddata = ramPipe1;

    function automatic vec_t mkVec(input logic r, input logic e, input logic rd,
                                   input logic xr, input logic [3:0] xa,
                                   input logic xv, input logic [31:0] xd);
        vec_t v;
        v.rst = r; v.empty = e; v.ready = rd;
        v.expRdreq = xr; v.expAddr = xa; v.expValid = xv; v.expData = xd;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic rd);
        rst       = r;
        empty     = e;
        out_ready = rd;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic resetCycle();
        applyStimulus(1'b1, 1'b1, 1'b0);
        nextCycle();
    endtask

    // Guard against a hung run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) ramMem[i] = 32'h100 + i;
        ramMem[0] = 32'hA5;
        nextCycle();

        // Reset release with a spurious empty=0, then a single read of 0xA5.
        for (int i = 0; i < 5; i++) vecs[i] = mkVec(1, 0, 1, 0, 4'd0, 0, 32'h0);
        vecs[5] = mkVec(0, 0, 1, 0, 4'd0, 0, 32'h0);
        for (int i = 6; i < 10; i++) vecs[i] = mkVec(0, 1, 1, 0, 4'd0, 0, 32'h0);
        vecs[10] = mkVec(0, 0, 1, 1, 4'd0, 0, 32'h0);
        vecs[11] = mkVec(0, 1, 1, 0, 4'd1, 0, 32'h0);
        vecs[12] = mkVec(0, 1, 1, 0, 4'd1, 0, 32'h0);
        vecs[13] = mkVec(0, 1, 1, 0, 4'd1, 1, 32'hA5);
        vecs[14] = mkVec(0, 1, 1, 0, 4'd1, 0, 32'h0);

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].empty, vecs[i].ready);
            @(negedge clk);
            checkOutput($sformatf("vec%0d rdreq", i), 32'(rdreq), 32'(vecs[i].expRdreq));
            checkOutput($sformatf("vec%0d addr", i), 32'(ram_rdaddr), 32'(vecs[i].expAddr));
            checkOutput($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].expValid));
            if (vecs[i].expValid) begin
                checkOutput($sformatf("vec%0d out_data", i), out_data, vecs[i].expData);
            end
            nextCycle();
        end
        ramMem[0] = 32'h100;

        // Streaming 20 words with the consumer always ready.
        resetCycle();
        applyStimulus(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("stream hold rdreq", 32'(rdreq), 32'd0);
        nextCycle();
        for (int c = 0; c < 24; c++) begin
            applyStimulus(1'b0, (c < 20) ? 1'b0 : 1'b1, 1'b1);
            @(negedge clk);
            checkOutput($sformatf("stream c%0d rdreq", c), 32'(rdreq), (c < 20) ? 32'd1 : 32'd0);
            if (c < 20) begin
                checkOutput($sformatf("stream c%0d addr", c), 32'(ram_rdaddr), 32'(c % 16));
            end
            checkOutput($sformatf("stream c%0d out_valid", c), 32'(out_valid),
                        (c >= 3 && c < 23) ? 32'd1 : 32'd0);
            if (c >= 3 && c < 23) begin
                checkOutput($sformatf("stream c%0d out_data", c), out_data,
                            32'h100 + 32'((c - 3) % 16));
            end
            nextCycle();
        end

        // Backpressure: exactly CAP reads, head held, then release.
        resetCycle();
        applyStimulus(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("bp hold rdreq", 32'(rdreq), 32'd0);
        nextCycle();
        for (int c = 0; c < 8; c++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            @(negedge clk);
            checkOutput($sformatf("bp c%0d rdreq", c), 32'(rdreq), (c < CAP) ? 32'd1 : 32'd0);
            if (c < CAP) begin
                checkOutput($sformatf("bp c%0d addr", c), 32'(ram_rdaddr), 32'(c));
            end
            checkOutput($sformatf("bp c%0d out_valid", c), 32'(out_valid), (c >= 3) ? 32'd1 : 32'd0);
            if (c >= 3) begin
                checkOutput($sformatf("bp c%0d out_data", c), out_data, 32'h100);
            end
            nextCycle();
        end
        for (int c = 0; c < 12; c++) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            @(negedge clk);
            checkOutput($sformatf("release c%0d rdreq", c), 32'(rdreq), (c >= 1) ? 32'd1 : 32'd0);
            if (c >= 1) begin
                checkOutput($sformatf("release c%0d addr", c), 32'(ram_rdaddr), 32'((c + 3) % 16));
            end
            checkOutput($sformatf("release c%0d out_valid", c), 32'(out_valid), 32'd1);
            checkOutput($sformatf("release c%0d out_data", c), out_data, 32'h100 + 32'(c));
            nextCycle();
        end

        // Reset with two reads in flight and one word buffered.
        resetCycle();
        applyStimulus(1'b0, 1'b0, 1'b0);
        nextCycle();
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            @(negedge clk);
            checkOutput($sformatf("midrst c%0d rdreq", c), 32'(rdreq), 32'd1);
            checkOutput($sformatf("midrst c%0d addr", c), 32'(ram_rdaddr), 32'(c));
            nextCycle();
        end
        applyStimulus(1'b1, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("midrst buffered valid", 32'(out_valid), 32'd1);
        checkOutput("midrst buffered data", out_data, 32'h100);
        checkOutput("midrst rdreq in rst", 32'(rdreq), 32'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("midrst hold rdreq", 32'(rdreq), 32'd0);
        checkOutput("midrst hold addr", 32'(ram_rdaddr), 32'd0);
        checkOutput("midrst flushed valid", 32'(out_valid), 32'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("midrst reissue rdreq", 32'(rdreq), 32'd1);
        checkOutput("midrst reissue addr", 32'(ram_rdaddr), 32'd0);
        checkOutput("midrst late data dropped c5", 32'(out_valid), 32'd0);
        nextCycle();
        for (int c = 6; c < 8; c++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            @(negedge clk);
            checkOutput($sformatf("midrst c%0d out_valid", c), 32'(out_valid), 32'd0);
            nextCycle();
        end
        applyStimulus(1'b0, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("midrst new word valid", 32'(out_valid), 32'd1);
        checkOutput("midrst new word data", out_data, 32'h100);
        nextCycle();
        @(negedge clk);
        checkOutput("midrst drained valid", 32'(out_valid), 32'd0);
        nextCycle();

        // Randomised empty/out_ready against an independent scoreboard.
        for (int i = 0; i < 16; i++) ramMem[i] = $urandom;
        resetCycle();
        expAddr   = 4'd0;
        transfers = 0;
        expQ.delete();
        for (int c = 0; c < 2030; c++) begin
            if (c < 2000) begin
                applyStimulus(1'b0, ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                              $urandom_range(0, 1) == 1 ? 1'b1 : 1'b0);
            end else begin
                applyStimulus(1'b0, 1'b1, 1'b1);
            end
            @(negedge clk);
            checkOutput("rand rdreq while empty", 32'(rdreq && empty), 32'd0);
            if (rdreq) begin
                checkOutput("rand addr", 32'(ram_rdaddr), 32'(expAddr));
                expQ.push_back(ramMem[expAddr]);
                expAddr = expAddr + 4'd1;
            end
            if (out_valid && out_ready) begin
                transfers++;
                if (expQ.size() == 0) begin
                    checkOutput("rand unexpected word", 32'd1, 32'd0);
                end else begin
                    checkOutput("rand out_data", out_data, expQ.pop_front());
                end
            end
            checkOutput("rand outstanding bound", 32'(expQ.size() <= CAP), 32'd1);
            nextCycle();
        end
        checkOutput("rand drained", 32'(expQ.size()), 32'd0);
        checkOutput("rand progress", 32'(transfers > 100), 32'd1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/kanagawa_fifo_read_prefetch.md
Name: kanagawa_fifo_read_prefetch

Overview:
Read-side stage that sits downstream of the FIFO pointer tracker, which supplies `empty` and receives `rdreq`.
It issues reads to a synchronous RAM of fixed latency and tracks the read address. Returned words land in a small prefetch buffer, which is presented to the consumer over a valid/ready interface.
It bounds outstanding reads so returned data is never dropped, and there is no combinational path from `out_ready` to `rdreq`.

Parameters:
WIDTH, 32, data word width in bits.
LOG_DEPTH, 5, log2 of the RAM depth; the read address wraps at 2**LOG_DEPTH.
READ_LATENCY, 2, cycles from RAM address to RAM data, >=1.
CAP (localparam), READ_LATENCY+2, prefetch buffer entries and the maximum number of reads in flight plus buffered.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
empty  in  1  from the pointer tracker; registered, updated the cycle after each rdreq
rdreq  out  1  pop request to the pointer tracker; also the RAM read enable
ram_rdaddr  out  LOG_DEPTH  RAM read address, valid when rdreq=1
ram_rddata  in  WIDTH  RAM read data, valid READ_LATENCY cycles after the matching rdreq
out_valid  out  1  prefetch buffer head valid
out_data  out  WIDTH  prefetch buffer head word
out_ready  in  1  consumer accept; a transfer occurs when out_valid && out_ready

Behaviour:
- Reset values: rdreq=0, ram_rdaddr=0, out_valid=0, out_data=don't-care.
  - Internal state is cleared: occupancy=0, in-flight shift register=0, buffer pointers=0.
  - A hold flag is set during rst.
- Post-reset hold: rdreq is forced to 0 during rst and for exactly 1 cycle after rst deasserts.
  - Reason: the upstream `empty` resets to 0 even though the FIFO is empty.
- Issue rule: rdreq = !hold && !empty && (occupancy < CAP).
  - This is combinational from registers only (hold, occupancy) and the registered `empty`.
- Address: rd_addr is LOG_DEPTH bits, driven on ram_rdaddr. It increments by 1 on every rdreq and wraps naturally at 2**LOG_DEPTH.
- In-flight tracking: a READ_LATENCY-deep valid shift register, fed by rdreq.
  - Its tail bit asserted in cycle t+READ_LATENCY means ram_rddata is valid in that cycle.
  - Data is written into the buffer at the end of that cycle.
- Prefetch buffer: CAP-entry circular buffer with wr_ptr, rd_ptr and count, all sized clog2(CAP)+1 bits.
  - out_valid = (count != 0); out_data = mem[rd_ptr].
  - Write and pop in the same cycle: count is unchanged and both pointers advance.
- Occupancy: counts in-flight plus buffered entries.
  - Increments on rdreq, decrements on pop (out_valid && out_ready).
  - rdreq and pop in the same cycle leave it unchanged.
  - Invariant: occupancy <= CAP, so the buffer never overflows.
- Latency: for rdreq in cycle t, out_valid is first 1 in cycle t+READ_LATENCY+1 (if the buffer was empty).
- Throughput: with out_ready=1 and empty=0, one rdreq and one transfer per cycle in steady state.
- Ordering: words are delivered strictly in issue order.
- Backpressure: while out_valid && !out_ready, out_data is stable.
  - rdreq stops once occupancy reaches CAP and resumes the cycle after the first pop.
- out_ready while !out_valid is ignored.
- Reset mid-operation: in-flight reads are discarded (their data is ignored), the buffer is flushed, and rd_addr returns to 0.
  - The pointer tracker is reset together with this block.
- Assertions (sim only): no rdreq while empty; occupancy <= CAP; no buffer write when count==CAP; out_data stable under backpressure.

Test Plan:
All scenarios use LOG_DEPTH=4, READ_LATENCY=2, CAP=4, WIDTH=32.
1. Reset released at cycle 5 with empty=0 at cycle 5 and empty=1 from cycle 6 -> rdreq=0 in cycles 0-5 and stays 0 while empty=1; no address increment.
2. empty falls at cycle 10, RAM returns 0xA5 at cycle 12, out_ready=1 -> rdreq=1 at cycle 10 with addr 0; out_valid=1 and out_data=0xA5 at cycle 13 only; occupancy back to 0 at cycle 14.
3. Streaming 20 words (data = addr+0x100), out_ready=1 -> rdreq every cycle; addresses 0..15 then 0..3; outputs 0x100..0x10F then 0x100..0x103 in order, one per cycle.
4. empty=0 throughout, out_ready=0 -> exactly 4 rdreq, then rdreq=0; out_data holds the first word. Raising out_ready -> all words delivered in order, rdreq resumes the next cycle, no loss or duplicate.
5. rst asserted for 1 cycle with 2 reads in flight and 1 word buffered -> out_valid=0 from the next cycle; late RAM data is not delivered; the next rdreq (after the 1-cycle hold) uses addr 0.
6. Randomised empty and out_ready for 2000 cycles against a scoreboard model -> delivered sequence equals issued address order; all assertions hold.
